// File: rtl/sdram_bus_bridge_pkg.sv
// Shared definitions for the 32-bit bus to 16-bit SDRAM host bridge:
// FSM state encodings and half-word select constants.
package sdram_bus_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_LO = 3'd1,
      GAP      = 3'd2,
      ISSUE_HI = 3'd3,
      DONE     = 3'd4
   } bridge_state_t;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sdram_bus_bridge.sv
// Splits 32-bit bus accesses into up to two 16-bit SDRAM controller accesses
// (low half first), merges read data and returns a single-cycle ack.
module sdram_bus_bridge
   import sdram_bus_bridge_pkg::*;
#(
   parameter int POSTED_WRITES = 0,
   parameter int ADDR_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bus_access,
   input  logic [29:0]           bus_addr,
   input  logic                  bus_wr_en,
   input  logic [3:0]            bus_bytesel,
   input  logic [31:0]           bus_wr_val,
   output logic [31:0]           bus_data,
   output logic                  bus_ack,
   output logic [ADDR_WIDTH-1:0] h_addr,
   output logic [15:0]           h_wdata,
   input  logic [15:0]           h_rdata,
   output logic                  h_wr_en,
   output logic [1:0]            h_bytesel,
   input  logic                  h_compl
);

   bridge_state_t state_q, state_d;
   logic [29:0]   addr_q, addr_d;
   logic          wr_en_q, wr_en_d;
   logic [3:0]    bytesel_q, bytesel_d;
   logic [31:0]   wr_val_q, wr_val_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          half_q, half_d;
   logic          pending_q, pending_d;

   logic          lo_en;
   logic          hi_en;
   logic          issuing;
   logic [31:0]   full_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         bytesel_q <= '0;
         wr_val_q  <= '0;
         rdata_q   <= '0;
         half_q    <= HALF_LO;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         bytesel_q <= bytesel_d;
         wr_val_q  <= wr_val_d;
         rdata_q   <= rdata_d;
         half_q    <= half_d;
         pending_q <= pending_d;
      end
   end

   assign lo_en = |bytesel_q[1:0];
   assign hi_en = |bytesel_q[3:2];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_en_d   = wr_en_q;
      bytesel_d = bytesel_q;
      wr_val_d  = wr_val_q;
      rdata_d   = rdata_q;
      half_d    = half_q;
      pending_d = pending_q;

      case (state_q)
         IDLE: begin
            if (bus_access && !pending_q) begin
               addr_d    = bus_addr;
               wr_en_d   = bus_wr_en;
               bytesel_d = bus_bytesel;
               wr_val_d  = bus_wr_val;
               rdata_d   = '0;
               half_d    = HALF_LO;
               // A posted write acks first; DONE then launches the halves.
               if ((POSTED_WRITES != 0) && bus_wr_en && (|bus_bytesel)) begin
                  pending_d = 1'b1;
                  state_d   = DONE;
               end else if (|bus_bytesel[1:0]) begin
                  state_d = ISSUE_LO;
               end else if (|bus_bytesel[3:2]) begin
                  half_d  = HALF_HI;
                  state_d = ISSUE_HI;
               end else begin
                  state_d = DONE;
               end
            end
         end

         ISSUE_LO: begin
            if (h_compl) begin
               if (!wr_en_q) begin
                  rdata_d[15:0] = h_rdata;
               end
               state_d = GAP;
            end
         end

         ISSUE_HI: begin
            if (h_compl) begin
               if (!wr_en_q) begin
                  rdata_d[31:16] = h_rdata;
               end
               state_d = GAP;
            end
         end

         GAP: begin
            if ((half_q == HALF_LO) && hi_en) begin
               half_d  = HALF_HI;
               state_d = ISSUE_HI;
            end else if (pending_q) begin
               // Background write finished; requester was already released.
               pending_d = 1'b0;
               state_d   = IDLE;
            end else begin
               state_d = DONE;
            end
         end

         DONE: begin
            if (pending_q) begin
               if (lo_en) begin
                  half_d  = HALF_LO;
                  state_d = ISSUE_LO;
               end else begin
                  half_d  = HALF_HI;
                  state_d = ISSUE_HI;
               end
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign issuing = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);

   always_comb begin
      h_bytesel = 2'b00;
      if (state_q == ISSUE_LO) begin
         h_bytesel = bytesel_q[1:0];
      end else if (state_q == ISSUE_HI) begin
         h_bytesel = bytesel_q[3:2];
      end
   end

   assign h_wr_en   = issuing && wr_en_q;
   assign h_wdata   = issuing ? ((half_q == HALF_HI) ? wr_val_q[31:16] : wr_val_q[15:0]) : 16'h0000;
   assign bus_ack   = (state_q == DONE);
   assign bus_data  = bus_ack ? rdata_q : 32'h0000_0000;
   assign full_addr = {addr_q, half_q, 1'b0};

   // Fit the 32-bit byte address to whatever host address width is configured.
   generate
      if (ADDR_WIDTH == 32) begin : g_addr_eq
         assign h_addr = full_addr;
      end else if (ADDR_WIDTH > 32) begin : g_addr_wide
         assign h_addr = {{(ADDR_WIDTH-32){1'b0}}, full_addr};
      end else begin : g_addr_narrow
         assign h_addr = full_addr[ADDR_WIDTH-1:0];
      end
   endgenerate

endmodule
